// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute stage of a single-cycle MIPS-style datapath.
//
// It combines the ALU-control decode (alu_op + funct), a WIDTH-bit ALU with a
// zero flag, and the branch-target adder. Every result is registered, so the
// outputs appear one clock after the inputs are presented.
//
// Ports:
//   clk, rst       rising-edge clock; synchronous active-high reset
//   in_valid       inputs valid this cycle
//   alu_op, funct  operation class from the main decoder; instruction[5:0]
//   operand_a/b    ALU operands
//   se_immediate   sign-extended instruction[15:0]
//   pc_next        PC+4
//   out_valid      registered in_valid
//   alu_ctrl       registered 4-bit ALU control code
//   alu_result     registered ALU result
//   zero           registered (alu_result == 0)
//   branch_target  registered pc_next + (se_immediate << 2)
//   illegal        registered: unsupported funct under alu_op=10
//   overflow       registered signed overflow for add/sub
//
// Build option: define ALU_OVERFLOW_DETECT_EN to enable signed-overflow
// detection. When it is undefined, overflow is the constant 0.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] se_immediate,
  input  logic [WIDTH-1:0] pc_next,
  output logic             out_valid,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] branch_target,
  output logic             illegal,
  output logic             overflow
);

  logic [3:0]       ctrl_c;
  logic             illegal_c;
  logic [WIDTH-1:0] result_c;
  logic [WIDTH-1:0] target_c;

  logic             out_valid_d, out_valid_q;
  logic [3:0]       alu_ctrl_d, alu_ctrl_q;
  logic [WIDTH-1:0] alu_result_d, alu_result_q;
  logic             zero_d, zero_q;
  logic [WIDTH-1:0] branch_target_d, branch_target_q;
  logic             illegal_d, illegal_q;

  // ALU-control decode
  always_comb begin
    ctrl_c    = 4'b0010;
    illegal_c = 1'b0;
    unique case (alu_op)
      2'b00: ctrl_c = 4'b0010;
      2'b01: ctrl_c = 4'b0110;
      2'b11: ctrl_c = 4'b0001;
      default: begin
        unique case (funct)
          6'b100000: ctrl_c = 4'b0010;
          6'b100010: ctrl_c = 4'b0110;
          6'b100100: ctrl_c = 4'b0000;
          6'b100101: ctrl_c = 4'b0001;
          6'b100111: ctrl_c = 4'b1100;
          6'b101010: ctrl_c = 4'b0111;
          default: begin
            ctrl_c    = 4'b1111;
            illegal_c = 1'b1;
          end
        endcase
      end
    endcase
  end

  // ALU datapath; undefined codes (including 1111) produce 0
  always_comb begin
    result_c = '0;
    case (ctrl_c)
      4'b0000: result_c = operand_a & operand_b;
      4'b0001: result_c = operand_a | operand_b;
      4'b0010: result_c = operand_a + operand_b;
      4'b0110: result_c = operand_a - operand_b;
      4'b0111: result_c = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      4'b1100: result_c = ~(operand_a | operand_b);
      default: result_c = '0;
    endcase
  end

  // Shifting the whole word keeps every immediate bit in use; the two bits
  // shifted out are only sign copies anyway.
  assign target_c = pc_next + (se_immediate << 2);

  // Data registers hold while no valid input is presented.
  always_comb begin
    out_valid_d     = in_valid;
    alu_ctrl_d      = alu_ctrl_q;
    alu_result_d    = alu_result_q;
    zero_d          = zero_q;
    branch_target_d = branch_target_q;
    illegal_d       = illegal_q;
    if (in_valid) begin
      alu_ctrl_d      = ctrl_c;
      alu_result_d    = result_c;
      zero_d          = (result_c == '0);
      branch_target_d = target_c;
      illegal_d       = illegal_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      alu_ctrl_q      <= '0;
      alu_result_q    <= '0;
      zero_q          <= 1'b0;
      branch_target_q <= '0;
      illegal_q       <= 1'b0;
    end else begin
      out_valid_q     <= out_valid_d;
      alu_ctrl_q      <= alu_ctrl_d;
      alu_result_q    <= alu_result_d;
      zero_q          <= zero_d;
      branch_target_q <= branch_target_d;
      illegal_q       <= illegal_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign alu_ctrl      = alu_ctrl_q;
  assign alu_result    = alu_result_q;
  assign zero          = zero_q;
  assign branch_target = branch_target_q;
  assign illegal       = illegal_q;

`ifdef ALU_OVERFLOW_DETECT_EN
  logic overflow_c;
  logic overflow_d, overflow_q;

  // Signed overflow is judged purely on sign bits of operands and result.
  always_comb begin
    overflow_c = 1'b0;
    if (ctrl_c == 4'b0010)
      overflow_c = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                   (result_c[WIDTH-1] != operand_a[WIDTH-1]);
    else if (ctrl_c == 4'b0110)
      overflow_c = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                   (result_c[WIDTH-1] != operand_a[WIDTH-1]);
  end

  always_comb begin
    overflow_d = overflow_q;
    if (in_valid) overflow_d = overflow_c;
  end

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  alu_op = '0;
  logic [5:0]  funct = '0;
  logic [31:0] operand_a = '0, operand_b = '0, se_immediate = '0, pc_next = '0;
  logic        out_valid, zero, illegal, overflow;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result, branch_target;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected registered state
  logic        e_valid = 0, e_zero = 0, e_ill = 0, e_ov = 0;
  logic [3:0]  e_ctrl = 0;
  logic [31:0] e_res = 0, e_bt = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op(alu_op), .funct(funct),
    .operand_a(operand_a), .operand_b(operand_b), .se_immediate(se_immediate),
    .pc_next(pc_next), .out_valid(out_valid), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .zero(zero), .branch_target(branch_target),
    .illegal(illegal), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what the stage should produce for one set of inputs.
  task automatic ref_compute(input logic [1:0] op, input logic [5:0] f,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic [31:0] pc,
                             output logic [3:0] ctrl, output logic [31:0] res,
                             output logic ill, output logic ov, output logic [31:0] bt);
    longint sa, sb, s;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ill = 0;
    ov  = 0;
    if (op == 2'd0) ctrl = 4'd2;
    else if (op == 2'd1) ctrl = 4'd6;
    else if (op == 2'd3) ctrl = 4'd1;
    else begin
      case (f)
        6'd32: ctrl = 4'd2;
        6'd34: ctrl = 4'd6;
        6'd36: ctrl = 4'd0;
        6'd37: ctrl = 4'd1;
        6'd39: ctrl = 4'd12;
        6'd42: ctrl = 4'd7;
        default: begin ctrl = 4'd15; ill = 1; end
      endcase
    end
    case (ctrl)
      4'd0:  res = a & b;
      4'd1:  res = a | b;
      4'd2:  begin s = sa + sb; res = 32'(a + b); end
      4'd6:  begin s = sa - sb; res = 32'(a - b); end
      4'd7:  res = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: res = ~(a | b);
      default: res = 32'd0;
    endcase
`ifdef ALU_OVERFLOW_DETECT_EN
    if (ctrl == 4'd2 || ctrl == 4'd6)
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`endif
    bt = 32'(pc + imm * 32'd4);
  endtask

  // Apply inputs for one cycle, advance the model, then check every output.
  task automatic cycle(input logic r, input logic v, input logic [1:0] op,
                       input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc);
    logic [3:0] c; logic [31:0] res, bt; logic il, ov;
    rst = r; in_valid = v; alu_op = op; funct = f;
    operand_a = a; operand_b = b; se_immediate = imm; pc_next = pc;
    ref_compute(op, f, a, b, imm, pc, c, res, il, ov, bt);
    @(posedge clk);
    if (r) begin
      e_valid = 0; e_ctrl = 0; e_res = 0; e_zero = 0; e_bt = 0; e_ill = 0; e_ov = 0;
    end else begin
      e_valid = v;
      if (v) begin
        e_ctrl = c; e_res = res; e_zero = (res == 0); e_bt = bt; e_ill = il; e_ov = ov;
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("alu_ctrl", 32'(alu_ctrl), 32'(e_ctrl));
    check("alu_result", alu_result, e_res);
    check("zero", 32'(zero), 32'(e_zero));
    check("branch_target", branch_target, e_bt);
    check("illegal", 32'(illegal), 32'(e_ill));
    check("overflow", 32'(overflow), 32'(e_ov));
  endtask

  initial begin
    logic [5:0] legal_f [6];
    legal_f = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      cycle(1, 1'($urandom), 2'($urandom), 6'($urandom), $urandom, $urandom, $urandom, $urandom);
    check("reset_result_zero", alu_result, 32'd0);

    cycle(0, 1, 2'b00, 6'd0, 32'd5, 32'd7, 32'd0, 32'd0);
    check("add_5_7", alu_result, 32'd12);

    // R-type sweep
    cycle(0, 1, 2'b10, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0);
    check("and_sweep", alu_result, 32'h00F000F0);
    cycle(0, 1, 2'b10, 6'b100101, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0);
    check("or_sweep", alu_result, 32'hFFF0FFF0);
    cycle(0, 1, 2'b10, 6'b100111, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0);
    check("nor_sweep", alu_result, 32'h000F000F);
    cycle(0, 1, 2'b10, 6'b100010, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0);
    check("sub_sweep", alu_result, 32'hE100E100);

    // Branch compare and backward target
    cycle(0, 1, 2'b01, 6'd0, 32'h1234, 32'h1234, 32'hFFFFFFFE, 32'h100);
    check("beq_zero", 32'(zero), 32'd1);
    check("beq_target", branch_target, 32'h0F8);

    // SLT signedness
    cycle(0, 1, 2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 0, 0);
    check("slt_neg", alu_result, 32'd1);
    cycle(0, 1, 2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, 0, 0);
    check("slt_swap", alu_result, 32'd0);

    // Illegal funct, then overflow boundary
    cycle(0, 1, 2'b10, 6'b000000, 32'h55, 32'h66, 0, 0);
    check("illegal_flag", 32'(illegal), 32'd1);
    cycle(0, 1, 2'b00, 6'd0, 32'h7FFFFFFF, 32'd1, 0, 0);
    check("add_wrap", alu_result, 32'h80000000);
    cycle(0, 1, 2'b01, 6'd0, 32'h80000000, 32'd1, 0, 0);

    // Hold while idle, then reset concurrent with a valid op
    cycle(0, 0, 2'b10, 6'b100100, 32'h1, 32'h2, 32'h3, 32'h4);
    cycle(0, 0, 2'b11, 6'd0, $urandom, $urandom, $urandom, $urandom);
    cycle(1, 1, 2'b00, 6'd0, 32'd9, 32'd9, 32'd1, 32'd1);
    check("reset_midstream", branch_target, 32'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [5:0] f;
      logic [31:0] a, b;
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 5)];
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      if ($urandom_range(0, 7) == 0) a = {1'b0, 31'h7FFFFFF0} + 32'($urandom_range(0, 31));
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 2'($urandom), f,
            a, b, $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
